// File: rtl/mc_pkg.sv
// Shared types and constants for the halfword-split SRAM controller.
package mc_pkg;

  localparam int HALF_W = 16;
  localparam int WORD_W = 32;

  localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mc_state_e;

  // Pick the halfword carried by a phase: low phase gets [15:0], high phase [31:16].
  function automatic logic [HALF_W-1:0] half_of(input logic [WORD_W-1:0] word, input logic hi);
    return hi ? word[WORD_W-1:HALF_W] : word[HALF_W-1:0];
  endfunction

endpackage

// File: rtl/sram_pins.sv
// SRAM pin stage: registered control/address outputs, the sram_dq tristate
// driver and the register that holds the low halfword of a read.
module sram_pins
  import mc_pkg::*;
#(
  parameter int SRAM_AW = 18
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               ce_n_d_i,
  input  logic               oe_n_d_i,
  input  logic               we_n_d_i,
  input  logic               addr_ld_i,
  input  logic [SRAM_AW-1:0] addr_d_i,
  input  logic [HALF_W-1:0]  dout_d_i,
  input  logic               cap_i,
  output logic [HALF_W-1:0]  din_o,
  output logic [HALF_W-1:0]  lo_o,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [HALF_W-1:0]  sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  logic               ce_n_q;
  logic               oe_n_q;
  logic               we_n_q;
  logic [SRAM_AW-1:0] addr_q;
  logic [HALF_W-1:0]  dout_q;
  logic [HALF_W-1:0]  lo_q;

  // Register the next-phase pin values; the address holds while deselected.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
      addr_q <= {SRAM_AW{1'b0}};
      dout_q <= {HALF_W{1'b0}};
    end else begin
      ce_n_q <= ce_n_d_i;
      oe_n_q <= oe_n_d_i;
      we_n_q <= we_n_d_i;
      dout_q <= dout_d_i;
      if (addr_ld_i) begin
        addr_q <= addr_d_i;
      end
    end
  end

  // Capture the low halfword on the last cycle of a read's low phase.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      lo_q <= {HALF_W{1'b0}};
    end else if (cap_i) begin
      lo_q <= sram_dq;
    end
  end

  // The bus is driven only while a write phase holds we_n low, so it
  // floats again on the first cycle after any write phase.
  assign sram_dq   = (!we_n_q) ? dout_q : {HALF_W{1'bz}};
  assign din_o     = sram_dq;
  assign lo_o      = lo_q;
  assign sram_addr = addr_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_ub_n = ce_n_q;
  assign sram_lb_n = ce_n_q;

endmodule

// File: rtl/memory_controller.sv
// Single-port SRAM controller shared by instruction fetch and the memory
// stage. Each 32-bit access runs as a low then a high halfword phase.
module memory_controller
  import mc_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_mc_en,
  input  logic [ADDR_W-1:0]  if_mc_addr,
  output logic [WORD_W-1:0]  mc_if_data,
  input  logic               mem_mc_en,
  input  logic               mem_mc_rw,
  input  logic [ADDR_W-1:0]  mem_mc_addr,
  input  logic [WORD_W-1:0]  mem_mc_wdata,
  output logic [WORD_W-1:0]  mc_mem_rdata,
  output logic               mc_stall,
  output logic [SRAM_AW-1:0] sram_addr,
  inout  wire  [HALF_W-1:0]  sram_dq,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);

  localparam int               CNT_W      = 3;
  localparam int               WIDX_W     = ADDR_W - 2;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  mc_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               op_q, op_d;
  logic               src_mem_q, src_mem_d;
  logic [WIDX_W-1:0]  widx_q, widx_d;
  logic [WORD_W-1:0]  wdata_q, wdata_d;
  logic [WORD_W-1:0]  if_data_q;
  logic [WORD_W-1:0]  mem_data_q;

  logic               phase_last;
  logic               cap_lo;
  logic               rd_done;
  logic               active_d;
  logic               hi_d;
  logic [SRAM_AW-1:0] pin_addr_d;
  logic [HALF_W-1:0]  pin_dout_d;
  logic [HALF_W-1:0]  din;
  logic [HALF_W-1:0]  lo_half;
  logic               unused_addr_lsb;

  // Byte-lane bits of the addresses are ignored: accesses are word aligned.
  assign unused_addr_lsb = ^{if_mc_addr[1:0], mem_mc_addr[1:0]};

  assign phase_last = (cnt_q == {CNT_W{1'b0}});
  assign cap_lo     = (state_q == LO) && phase_last && (op_q == OP_RD);
  assign rd_done    = (state_q == HI) && phase_last && (op_q == OP_RD);

  // Arbitration, phase sequencing and request latching.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    src_mem_d = src_mem_q;
    widx_d    = widx_q;
    wdata_d   = wdata_q;
    case (state_q)
      IDLE: begin
        if (mem_mc_en) begin
          state_d   = LO;
          cnt_d     = CNT_RELOAD;
          op_d      = mem_mc_rw;
          src_mem_d = 1'b1;
          widx_d    = mem_mc_addr[ADDR_W-1:2];
          wdata_d   = mem_mc_wdata;
        end else if (if_mc_en) begin
          state_d   = LO;
          cnt_d     = CNT_RELOAD;
          op_d      = OP_RD;
          src_mem_d = 1'b0;
          widx_d    = if_mc_addr[ADDR_W-1:2];
        end else begin
          state_d = IDLE;
        end
      end
      LO: begin
        if (phase_last) begin
          state_d = HI;
          cnt_d   = CNT_RELOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      HI: begin
        if (phase_last) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pin values for the coming cycle, decoded from the next state so the
  // registered pins line up with the phase they belong to.
  assign active_d   = (state_d == LO) || (state_d == HI);
  assign hi_d       = (state_d == HI);
  assign pin_addr_d = SRAM_AW'({1'b0, widx_d, hi_d});
  assign pin_dout_d = half_of(wdata_d, hi_d);

  // FSM, phase counter and latched request.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      op_q      <= OP_RD;
      src_mem_q <= 1'b0;
      widx_q    <= {WIDX_W{1'b0}};
      wdata_q   <= {WORD_W{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      src_mem_q <= src_mem_d;
      widx_q    <= widx_d;
      wdata_q   <= wdata_d;
    end
  end

  // Completed reads land in their requester's data register at the end of HI.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      if_data_q  <= NOP_WORD;
      mem_data_q <= NOP_WORD;
    end else if (rd_done && src_mem_q) begin
      mem_data_q <= {din, lo_half};
    end else if (rd_done) begin
      if_data_q <= {din, lo_half};
    end
  end

  assign mc_if_data   = if_data_q;
  assign mc_mem_rdata = mem_data_q;
  assign mc_stall     = ((state_q == IDLE) && (if_mc_en || mem_mc_en)) ||
                        (state_q == LO) || (state_q == HI);

  sram_pins #(
    .SRAM_AW (SRAM_AW)
  ) u_pins (
    .clock     (clock),
    .reset     (reset),
    .ce_n_d_i  (!active_d),
    .oe_n_d_i  (!(active_d && (op_d == OP_RD))),
    .we_n_d_i  (!(active_d && (op_d == OP_WR))),
    .addr_ld_i (active_d),
    .addr_d_i  (pin_addr_d),
    .dout_d_i  (pin_dout_d),
    .cap_i     (cap_lo),
    .din_o     (din),
    .lo_o      (lo_half),
    .sram_addr (sram_addr),
    .sram_dq   (sram_dq),
    .sram_ce_n (sram_ce_n),
    .sram_oe_n (sram_oe_n),
    .sram_we_n (sram_we_n),
    .sram_ub_n (sram_ub_n),
    .sram_lb_n (sram_lb_n)
  );

endmodule

// File: tb/tb_memory_controller.sv
// Bench for memory_controller: instance 0 (no wait states) is checked every
// cycle against a transaction-level model; instance 1 (two wait states) is
// checked with directed expectations.
module tb_memory_controller;

  localparam int W0  = 0;
  localparam int L0  = 2 * (1 + W0);
  localparam int PH0 = 1 + W0;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- instance 0 ----------------
  logic        reset0, if_en0, mem_en0, mem_rw0;
  logic [17:0] if_addr0, mem_addr0, sram_addr0;
  logic [31:0] mem_wdata0, if_data0, mem_rdata0;
  logic        stall0, ce_n0, oe_n0, we_n0, ub_n0, lb_n0;
  wire  [15:0] dq0;

  // ---------------- instance 1 ----------------
  logic        reset1, if_en1, mem_en1, mem_rw1;
  logic [17:0] if_addr1, mem_addr1, sram_addr1;
  logic [31:0] mem_wdata1, if_data1, mem_rdata1;
  logic        stall1, ce_n1, oe_n1, we_n1, ub_n1, lb_n1;
  wire  [15:0] dq1;

  memory_controller #(.ADDR_W(18), .SRAM_AW(18), .WAIT_CYCLES(W0)) dut0 (
    .clock(clock), .reset(reset0),
    .if_mc_en(if_en0), .if_mc_addr(if_addr0), .mc_if_data(if_data0),
    .mem_mc_en(mem_en0), .mem_mc_rw(mem_rw0), .mem_mc_addr(mem_addr0),
    .mem_mc_wdata(mem_wdata0), .mc_mem_rdata(mem_rdata0), .mc_stall(stall0),
    .sram_addr(sram_addr0), .sram_dq(dq0), .sram_ce_n(ce_n0), .sram_oe_n(oe_n0),
    .sram_we_n(we_n0), .sram_ub_n(ub_n0), .sram_lb_n(lb_n0)
  );

  memory_controller #(.ADDR_W(18), .SRAM_AW(18), .WAIT_CYCLES(2)) dut1 (
    .clock(clock), .reset(reset1),
    .if_mc_en(if_en1), .if_mc_addr(if_addr1), .mc_if_data(if_data1),
    .mem_mc_en(mem_en1), .mem_mc_rw(mem_rw1), .mem_mc_addr(mem_addr1),
    .mem_mc_wdata(mem_wdata1), .mc_mem_rdata(mem_rdata1), .mc_stall(stall1),
    .sram_addr(sram_addr1), .sram_dq(dq1), .sram_ce_n(ce_n1), .sram_oe_n(oe_n1),
    .sram_we_n(we_n1), .sram_ub_n(ub_n1), .sram_lb_n(lb_n1)
  );

  // ---------------- asynchronous SRAM models ----------------
  logic [15:0] sram0   [0:262143];
  logic [15:0] shadow0 [0:262143];
  logic [15:0] sram1   [0:262143];
  logic        pl_we0, pl_we1;
  logic [17:0] pl_a;
  logic [15:0] pl_d;

  assign dq0 = (!ce_n0 && !oe_n0 && we_n0) ? sram0[sram_addr0] : 16'hzzzz;
  assign dq1 = (!ce_n1 && !oe_n1 && we_n1) ? sram1[sram_addr1] : 16'hzzzz;

  always @(posedge clock) begin
    if (pl_we0) sram0[pl_a] <= pl_d;
    else if (!ce_n0 && !we_n0) sram0[sram_addr0] <= dq0;
  end

  always @(posedge clock) begin
    if (pl_we1) sram1[pl_a] <= pl_d;
    else if (!ce_n1 && !we_n1) sram1[sram_addr1] <= dq1;
  end

  // ---------------- transaction-level model of instance 0 ----------------
  // m_t: 0 = idle, 1..L0 = cycles of the access, L0+1 = completion cycle.
  int          m_t;
  logic        m_rw, m_src_mem;
  logic [15:0] m_word;
  logic [31:0] m_wd, exp_if, exp_mem;

  always @(posedge clock or posedge reset0) begin
    if (pl_we0) shadow0[pl_a] <= pl_d;
    if (reset0) begin
      m_t <= 0; exp_if <= 32'h0; exp_mem <= 32'h0;
    end else if (m_t == 0) begin
      if (mem_en0) begin
        m_t <= 1; m_rw <= mem_rw0; m_src_mem <= 1'b1;
        m_word <= mem_addr0[17:2]; m_wd <= mem_wdata0;
      end else if (if_en0) begin
        m_t <= 1; m_rw <= 1'b0; m_src_mem <= 1'b0; m_word <= if_addr0[17:2];
      end
    end else if (m_t < L0) begin
      m_t <= m_t + 1;
    end else if (m_t == L0) begin
      m_t <= L0 + 1;
      if (m_rw) begin
        shadow0[{1'b0, m_word, 1'b0}] <= m_wd[15:0];
        shadow0[{1'b0, m_word, 1'b1}] <= m_wd[31:16];
      end else if (m_src_mem) begin
        exp_mem <= {shadow0[{1'b0, m_word, 1'b1}], shadow0[{1'b0, m_word, 1'b0}]};
      end else begin
        exp_if <= {shadow0[{1'b0, m_word, 1'b1}], shadow0[{1'b0, m_word, 1'b0}]};
      end
    end else begin
      m_t <= 0;
    end
  end

  logic        c_act, c_hi, c_stall;
  logic [17:0] c_addr;
  logic [15:0] c_half;
  assign c_act   = (m_t >= 1) && (m_t <= L0);
  assign c_hi    = (m_t > PH0);
  assign c_stall = ((m_t == 0) && (if_en0 || mem_en0)) || c_act;
  assign c_addr  = {1'b0, m_word, c_hi};
  assign c_half  = c_hi ? m_wd[31:16] : m_wd[15:0];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of instance 0 against the model.
  always @(negedge clock) begin
    if (!reset0) begin
      chk("stall", 32'(stall0), 32'(c_stall));
      chk("ce_n", 32'(ce_n0), 32'(!c_act));
      chk("ub_lb_n", 32'({ub_n0, lb_n0}), 32'({!c_act, !c_act}));
      chk("oe_n", 32'(oe_n0), 32'(!(c_act && !m_rw)));
      chk("we_n", 32'(we_n0), 32'(!(c_act && m_rw)));
      chk("if_data", if_data0, exp_if);
      chk("mem_rdata", mem_rdata0, exp_mem);
      if (c_act) chk("sram_addr", 32'(sram_addr0), 32'(c_addr));
      if (c_act && m_rw) chk("dq_write", 32'(dq0), 32'(c_half));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic preload(input logic sel, input logic [17:0] a, input logic [15:0] d);
    pl_a = a; pl_d = d;
    if (sel) pl_we1 = 1'b1; else pl_we0 = 1'b1;
    @(posedge clock); #1;
    pl_we0 = 1'b0; pl_we1 = 1'b0;
  endtask

  // Present a request to instance 0 and wait for the completion cycle.
  task automatic run0(input logic m_en, input logic rw, input logic [17:0] ma,
                      input logic [31:0] wd, input logic f_en, input logic [17:0] fa,
                      output int ns, output int nwe,
                      output logic [17:0] a_first, output logic [17:0] a_last);
    bit seen;
    ns = 0; nwe = 0; a_first = 18'h0; a_last = 18'h0; seen = 1'b0;
    mem_en0 = m_en; mem_rw0 = rw; mem_addr0 = ma; mem_wdata0 = wd;
    if_en0 = f_en; if_addr0 = fa;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!stall0) break;
      ns++;
      if (!we_n0) nwe++;
      if (!ce_n0) begin
        if (!seen) a_first = sram_addr0;
        seen = 1'b1;
        a_last = sram_addr0;
      end
    end
    chk("done_reached", 32'(stall0), 32'd0);
  endtask

  task automatic release0();
    @(posedge clock); #1;
    mem_en0 = 1'b0; if_en0 = 1'b0;
  endtask

  int          ns, nwe, n4, n5;
  logic [17:0] af, al;

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    if_en0 = 1'b0; mem_en0 = 1'b0; mem_rw0 = 1'b0;
    if_addr0 = 18'h0; mem_addr0 = 18'h0; mem_wdata0 = 32'h0;
    if_en1 = 1'b0; mem_en1 = 1'b0; mem_rw1 = 1'b0;
    if_addr1 = 18'h0; mem_addr1 = 18'h0; mem_wdata1 = 32'h0;
    pl_we0 = 1'b0; pl_we1 = 1'b0; pl_a = 18'h0; pl_d = 16'h0;
    @(posedge clock); #1;

    preload(1'b0, 18'h00000, 16'h1111); preload(1'b0, 18'h00001, 16'h2222);
    preload(1'b0, 18'h00002, 16'h5555); preload(1'b0, 18'h00003, 16'h6666);
    preload(1'b0, 18'h00006, 16'h7777); preload(1'b0, 18'h00007, 16'h8888);
    preload(1'b0, 18'h00010, 16'h3333); preload(1'b0, 18'h00011, 16'h4444);
    preload(1'b0, 18'h1FFFE, 16'h0123); preload(1'b0, 18'h1FFFF, 16'h4567);
    preload(1'b1, 18'h00004, 16'hAAAA); preload(1'b1, 18'h00005, 16'h5555);

    // Reset state.
    @(negedge clock);
    chk("rst_if_data", if_data0, 32'h0);
    chk("rst_mem_rdata", mem_rdata0, 32'h0);
    chk("rst_stall", 32'(stall0), 32'd0);
    chk("rst_ctrl_n", 32'({ce_n0, oe_n0, we_n0, ub_n0, lb_n0}), 32'h1F);
    chk("rst_sram_addr", 32'(sram_addr0), 32'h0);
    chk("rst_if_data1", if_data1, 32'h0);
    @(posedge clock); #1;
    reset0 = 1'b0; reset1 = 1'b0;

    // Fetch of word 0.
    run0(1'b0, 1'b0, 18'h0, 32'h0, 1'b1, 18'h00000, ns, nwe, af, al);
    chk("fetch_stall_cycles", 32'(ns), 32'd3);
    chk("fetch_addr_lo", 32'(af), 32'h0);
    chk("fetch_addr_hi", 32'(al), 32'h1);
    chk("fetch_data", if_data0, 32'h2222_1111);
    release0();

    // Memory write to 0x00010.
    run0(1'b1, 1'b1, 18'h00010, 32'hDEAD_BEEF, 1'b0, 18'h0, ns, nwe, af, al);
    chk("wr_stall_cycles", 32'(ns), 32'd3);
    chk("wr_we_cycles", 32'(nwe), 32'd2);
    chk("wr_if_unchanged", if_data0, 32'h2222_1111);
    chk("wr_mem_unchanged", mem_rdata0, 32'h0);
    release0();
    chk("wr_sram8", 32'(sram0[18'h8]), 32'h0000_BEEF);
    chk("wr_sram9", 32'(sram0[18'h9]), 32'h0000_DEAD);

    // Read-back of the written word.
    run0(1'b1, 1'b0, 18'h00010, 32'h0, 1'b0, 18'h0, ns, nwe, af, al);
    chk("readback", mem_rdata0, 32'hDEAD_BEEF);
    release0();

    // Simultaneous requests: memory read first, fetch follows.
    run0(1'b1, 1'b0, 18'h00020, 32'h0, 1'b1, 18'h0000C, ns, nwe, af, al);
    chk("prio_mem_first", mem_rdata0, 32'h4444_3333);
    chk("prio_if_pending", if_data0, 32'h2222_1111);
    chk("prio_stall1", 32'(ns), 32'd3);
    @(posedge clock); #1;
    run0(1'b0, 1'b0, 18'h0, 32'h0, 1'b1, 18'h0000C, ns, nwe, af, al);
    chk("prio_stall2", 32'(ns), 32'd3);
    chk("prio_if_data", if_data0, 32'h8888_7777);
    release0();

    // Top of the address range.
    run0(1'b0, 1'b0, 18'h0, 32'h0, 1'b1, 18'h3FFFF, ns, nwe, af, al);
    chk("top_addr_lo", 32'(af), 32'h1FFFE);
    chk("top_addr_hi", 32'(al), 32'h1FFFF);
    chk("top_data", if_data0, 32'h4567_0123);
    release0();

    // Reset pulse during the HI phase of a fetch of 0x00004.
    if_addr0 = 18'h00004; if_en0 = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    reset0 = 1'b1;
    #1;
    chk("abort_if_data", if_data0, 32'h0);
    chk("abort_mem_rdata", mem_rdata0, 32'h0);
    chk("abort_ctrl_n", 32'({ce_n0, oe_n0, we_n0}), 32'h7);
    @(posedge clock); #1;
    reset0 = 1'b0;
    run0(1'b0, 1'b0, 18'h0, 32'h0, 1'b1, 18'h00004, ns, nwe, af, al);
    chk("restart_stall", 32'(ns), 32'd3);
    chk("restart_data", if_data0, 32'h6666_5555);
    release0();

    // Two wait states on instance 1.
    ns = 0; n4 = 0; n5 = 0;
    if_addr1 = 18'h00008; if_en1 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (!stall1) break;
      ns++;
      if (!ce_n1 && sram_addr1 == 18'h4) n4++;
      if (!ce_n1 && sram_addr1 == 18'h5) n5++;
    end
    chk("w2_done_reached", 32'(stall1), 32'd0);
    chk("w2_stall_cycles", 32'(ns), 32'd7);
    chk("w2_lo_phase", 32'(n4), 32'd3);
    chk("w2_hi_phase", 32'(n5), 32'd3);
    chk("w2_data", if_data1, 32'h5555_AAAA);
    @(posedge clock); #1;
    if_en1 = 1'b0;
    @(negedge clock);
    chk("w2_idle_ce_n", 32'(ce_n1), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
